// File: rtl/ram_banked_pkg.sv
// Shared types, helpers and default-derived widths for the banked scratch RAM.
package ram_banked_pkg;

  localparam int unsigned DEF_WIDTH      = 8;
  localparam int unsigned DEF_BANK_DEPTH = 2;
  localparam int unsigned DEF_BANKS      = 2;

  // Ceiling log2; returns 0 for v <= 1.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(v)) r = 32'(i + 1);
    end
    return r;
  endfunction

  localparam int unsigned BW = clog2(DEF_BANKS);
  localparam int unsigned RW = clog2(DEF_BANK_DEPTH);
  localparam int unsigned AW = BW + RW;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } state_e;

endpackage

// File: rtl/ram_banked_sweep_bank.sv
// One RAM bank: synchronous write, synchronous row clear (wins over write),
// combinational row read.
import ram_banked_pkg::*;

module ram_bank #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 8
) (
  input  logic                    clk_i,
  input  logic                    wr_en_i,
  input  logic [clog2(DEPTH)-1:0] wr_row_i,
  input  logic [W-1:0]            wr_word_i,
  input  logic                    clr_en_i,
  input  logic [clog2(DEPTH)-1:0] clr_row_i,
  input  logic [clog2(DEPTH)-1:0] rd_row_i,
  output logic [W-1:0]            rd_word_c_o
);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (clr_en_i) begin
      mem_q[clr_row_i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_row_i] <= wr_word_i;
    end
  end

  assign rd_word_c_o = mem_q[rd_row_i];

endmodule

// File: rtl/ram_banked_sweep.sv
// Banked scratch RAM with registered reads and a multi-cycle clear sweep.
// Define RAM_BANKED_PARITY_EN to store an even-parity bit per word and add par_err_o.
import ram_banked_pkg::*;

module ram_banked_sweep #(
  parameter int unsigned WIDTH      = DEF_WIDTH,
  parameter int unsigned BANK_DEPTH = DEF_BANK_DEPTH,
  parameter int unsigned BANKS      = DEF_BANKS
) (
  input  logic                                          clk_i,
  input  logic                                          clr_i,
  input  logic                                          en_i,
  input  logic                                          r_w_i,
  input  logic [clog2(BANKS)+clog2(BANK_DEPTH)-1:0]     addr_i,
  input  logic [WIDTH-1:0]                              data_in_i,
  input  logic                                          zero_req_i,
  output logic [WIDTH-1:0]                              data_out_o,
  output logic                                          rd_valid_o,
  output logic                                          busy_o,
`ifdef RAM_BANKED_PARITY_EN
  output logic                                          par_err_o,
`endif
  output logic                                          rej_o
);

  localparam int unsigned BANK_W = clog2(BANKS);
  localparam int unsigned ROW_W  = clog2(BANK_DEPTH);
  localparam int unsigned ADDR_W = BANK_W + ROW_W;
`ifdef RAM_BANKED_PARITY_EN
  localparam int unsigned MEM_W  = WIDTH + 1;
`else
  localparam int unsigned MEM_W  = WIDTH;
`endif

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   data_out_q, data_out_d;
  logic               rd_valid_q, rd_valid_d;
  logic               rej_q, rej_d;
  logic               busy_q, busy_d;
  logic               wr_en_c, sweep_en_c;
  logic [BANK_W-1:0]  bank_c;
  logic [ROW_W-1:0]   row_c;
  logic [MEM_W-1:0]   wr_word_c, rd_word_c;
  logic [MEM_W-1:0]   rd_words [BANKS];

  assign bank_c = addr_i[ADDR_W-1 -: BANK_W];
  assign row_c  = addr_i[ROW_W-1:0];
  assign rd_word_c = rd_words[bank_c];

`ifdef RAM_BANKED_PARITY_EN
  logic par_err_q, par_err_d;
  assign wr_word_c = {^data_in_i, data_in_i};
  assign par_err_o = par_err_q;
`else
  assign wr_word_c = data_in_i;
`endif

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    ram_bank #(.DEPTH(BANK_DEPTH), .W(MEM_W)) u_bank (
      .clk_i       (clk_i),
      .wr_en_i     (wr_en_c && (bank_c == BANK_W'(b))),
      .wr_row_i    (row_c),
      .wr_word_i   (wr_word_c),
      .clr_en_i    (sweep_en_c),
      .clr_row_i   (cnt_q),
      .rd_row_i    (row_c),
      .rd_word_c_o (rd_words[b])
    );
  end

  // Next-state, access arbitration and output staging.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    rd_valid_d = 1'b0;
    rej_d      = 1'b0;
    wr_en_c    = 1'b0;
    sweep_en_c = 1'b0;
`ifdef RAM_BANKED_PARITY_EN
    par_err_d  = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (zero_req_i) begin
          state_d = ST_SWEEP;
          cnt_d   = '0;
          rej_d   = en_i;
        end else if (en_i) begin
          if (r_w_i) begin
            wr_en_c = 1'b1;
          end else begin
            data_out_d = rd_word_c[WIDTH-1:0];
            rd_valid_d = 1'b1;
`ifdef RAM_BANKED_PARITY_EN
            par_err_d  = ^rd_word_c;
`endif
          end
        end
      end
      ST_SWEEP: begin
        sweep_en_c = 1'b1;
        rej_d      = en_i;
        if (zero_req_i) begin
          cnt_d = '0;
        end else if (cnt_q == ROW_W'(BANK_DEPTH - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ROW_W'(1);
        end
      end
      default: state_d = ST_SWEEP;
    endcase
    // Memory is left untouched on the reset edge itself.
    if (clr_i) begin
      wr_en_c    = 1'b0;
      sweep_en_c = 1'b0;
    end
    busy_d = (state_d == ST_SWEEP);
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state_q    <= ST_SWEEP;
      cnt_q      <= '0;
      data_out_q <= '0;
      rd_valid_q <= 1'b0;
      rej_q      <= 1'b0;
      busy_q     <= 1'b1;
`ifdef RAM_BANKED_PARITY_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
      rd_valid_q <= rd_valid_d;
      rej_q      <= rej_d;
      busy_q     <= busy_d;
`ifdef RAM_BANKED_PARITY_EN
      par_err_q  <= par_err_d;
`endif
    end
  end

  assign data_out_o = data_out_q;
  assign rd_valid_o = rd_valid_q;
  assign rej_o      = rej_q;
  assign busy_o     = busy_q;

endmodule
